// File: rtl/adc_limit_interlock_pkg.sv
// Shared definitions for the ADC limit interlock.
// Holds the FSM state encodings, the default sizes and the channel index map
// that tells which monitor lane carries which ADC measurement.
package adc_intl_pkg;

    localparam int CH_NUM_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DLY_W_DEF  = 16;

    localparam logic [1:0] ST_ARMED = 2'd0;
    localparam logic [1:0] ST_TRIP  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Channel index map
    localparam int CH_OUT_C   = 0;
    localparam int CH_OUT_V   = 1;
    localparam int CH_DC_C    = 2;
    localparam int CH_DC_V    = 3;
    localparam int CH_PHASE_R = 4;
    localparam int CH_PHASE_S = 5;
    localparam int CH_PHASE_T = 6;
    localparam int CH_IGBT_T  = 7;
    localparam int CH_I_IND_T = 8;
    localparam int CH_O_IND_T = 9;

endpackage

// File: rtl/intl_ch_monitor.sv
// Single-channel limit monitor.
// Signed window compare of one sample against min/max, a saturating count of
// consecutive out-of-range samples, and a combinational trip pulse asserted on
// the strobe whose sample reaches the debounce threshold.
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_data/i_max/i_min signed sample and limits
//   i_valid, i_en      sample strobe, channel enable
//   i_dly              debounce threshold (0 behaves as 1)
//   o_trip             trip pulse, same cycle as the qualifying strobe
//   o_cnt_zero         debounce count is zero
module intl_ch_monitor #(
    parameter int DATA_W = 32,
    parameter int DLY_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] i_max,
    input  logic signed [DATA_W-1:0] i_min,
    input  logic                     i_valid,
    input  logic                     i_en,
    input  logic [DLY_W-1:0]         i_dly,
    output logic                     o_trip,
    output logic                     o_cnt_zero
);

    logic [DLY_W-1:0] cnt;
    logic [DLY_W:0]   cnt_inc;
    logic [DLY_W:0]   dly_eff;
    logic             oor;

    // min > max makes every sample out of range, so a misconfigured window trips
    assign oor     = (i_data > i_max) || (i_data < i_min);
    assign cnt_inc = {1'b0, cnt} + (DLY_W+1)'(1);
    assign dly_eff = (i_dly == '0) ? (DLY_W+1)'(1) : {1'b0, i_dly};

    assign o_trip     = i_valid && i_en && oor && (cnt_inc >= dly_eff);
    assign o_cnt_zero = (cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (!i_en) begin
            cnt <= '0;
        end else if (i_valid) begin
            if (!oor)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt_inc[DLY_W-1:0];
        end
    end

endmodule

// File: rtl/adc_limit_interlock.sv
// Limit-check and interlock stage behind the ADC hold registers.
// One intl_ch_monitor per channel; this level latches per-channel faults,
// captures the first fault (lowest index wins on ties), runs the interlock FSM
// and emits the one-shot DDR capture trigger.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_data, i_valid       packed samples and per-channel strobes
//   i_max, i_min          packed signed limits
//   i_ch_en, i_dly        channel enables, debounce threshold
//   i_intl_clr            interlock clear request
//   o_intl, o_intl_flag   global interlock, latched channel flags
//   o_first_ch/_val       first-fault channel and sample
//   o_ddr_trig            one-cycle pulse on entry into TRIP
//   o_state               FSM state
//
// state | meaning
// ARMED | no fault latched, waiting for a trip
// TRIP  | fault latched, first-fault data frozen, waiting for clear
// HOLD  | clearing flags whose counters are idle; re-arm on clear release
module adc_limit_interlock
    import adc_intl_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DLY_W  = DLY_W_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [CH_NUM*DATA_W-1:0]   i_data,
    input  logic [CH_NUM-1:0]          i_valid,
    input  logic [CH_NUM*DATA_W-1:0]   i_max,
    input  logic [CH_NUM*DATA_W-1:0]   i_min,
    input  logic [CH_NUM-1:0]          i_ch_en,
    input  logic [DLY_W-1:0]           i_dly,
    input  logic                       i_intl_clr,
    output logic                       o_intl,
    output logic [CH_NUM-1:0]          o_intl_flag,
    output logic [$clog2(CH_NUM)-1:0]  o_first_ch,
    output logic [DATA_W-1:0]          o_first_val,
    output logic                       o_ddr_trig,
    output logic [1:0]                 o_state
);

    localparam int IDX_W = $clog2(CH_NUM);

    logic [CH_NUM-1:0] trip;
    logic [CH_NUM-1:0] cnt_zero;
    logic [CH_NUM-1:0] flag_q;
    logic [CH_NUM-1:0] flag_nxt;
    logic [1:0]        state_q;
    logic [1:0]        state_nxt;
    logic [IDX_W-1:0]  first_ch_q;
    logic [DATA_W-1:0] first_val_q;
    logic              ddr_q;
    logic [IDX_W-1:0]  enc_ch;
    logic [DATA_W-1:0] enc_val;
    logic              new_trip;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_mon
        intl_ch_monitor #(
            .DATA_W (DATA_W),
            .DLY_W  (DLY_W)
        ) u_mon (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_data     (i_data[g*DATA_W +: DATA_W]),
            .i_max      (i_max[g*DATA_W +: DATA_W]),
            .i_min      (i_min[g*DATA_W +: DATA_W]),
            .i_valid    (i_valid[g]),
            .i_en       (i_ch_en[g]),
            .i_dly      (i_dly),
            .o_trip     (trip[g]),
            .o_cnt_zero (cnt_zero[g])
        );
    end

    assign new_trip = |trip;

    // Descending scan so the lowest tripping index is the one left standing
    always_comb begin
        enc_ch  = '0;
        enc_val = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (trip[i]) begin
                enc_ch  = IDX_W'(i);
                enc_val = i_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Trip is ORed in after the HOLD clear so a same-cycle trip keeps its flag
    always_comb begin
        flag_nxt = flag_q;
        if (state_q == ST_HOLD)
            flag_nxt = flag_q & ~cnt_zero;
        flag_nxt = flag_nxt | trip;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_ARMED;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_ARMED: if (new_trip) state_nxt = ST_TRIP;
            ST_TRIP:  if (i_intl_clr) state_nxt = ST_HOLD;
            ST_HOLD:  if ((flag_nxt == '0) && !i_intl_clr) state_nxt = ST_ARMED;
            default:  state_nxt = ST_ARMED;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flag_q      <= '0;
            first_ch_q  <= '0;
            first_val_q <= '0;
            ddr_q       <= 1'b0;
        end else begin
            flag_q <= flag_nxt;
            ddr_q  <= (state_q == ST_ARMED) && new_trip;
            if ((state_q == ST_ARMED) && new_trip) begin
                first_ch_q  <= enc_ch;
                first_val_q <= enc_val;
            end else if ((state_q == ST_HOLD) && (state_nxt == ST_ARMED)) begin
                first_ch_q  <= '0;
                first_val_q <= '0;
            end
        end
    end

    always_comb begin
        o_state     = state_q;
        o_intl_flag = flag_q;
        o_intl      = |flag_q;
        o_first_ch  = first_ch_q;
        o_first_val = first_val_q;
        o_ddr_trig  = ddr_q;
    end

endmodule

// File: tb/tb_adc_limit_interlock.sv
module tb_adc_limit_interlock;

    localparam int CH = 10;
    localparam int DW = 32;
    localparam int LW = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH*DW-1:0]   data;
    logic [CH-1:0]      valid;
    logic [CH*DW-1:0]   lim_max;
    logic [CH*DW-1:0]   lim_min;
    logic [CH-1:0]      ch_en;
    logic [LW-1:0]      dly;
    logic               clr;
    logic               intl;
    logic [CH-1:0]      flag;
    logic [3:0]         first_ch;
    logic [DW-1:0]      first_val;
    logic               ddr;
    logic [1:0]         state;

    int cmp  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    adc_limit_interlock #(.CH_NUM(CH), .DATA_W(DW), .DLY_W(LW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .i_max       (lim_max),
        .i_min       (lim_min),
        .i_ch_en     (ch_en),
        .i_dly       (dly),
        .i_intl_clr  (clr),
        .o_intl      (intl),
        .o_intl_flag (flag),
        .o_first_ch  (first_ch),
        .o_first_val (first_val),
        .o_ddr_trig  (ddr),
        .o_state     (state)
    );

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        clr   = 1'b0;
        dly   = '0;
        ch_en = '1;
        data  = '0;
        for (int k = 0; k < CH; k++) begin
            lim_max[k*DW +: DW] = 32'sd1000;
            lim_min[k*DW +: DW] = -32'sd1000;
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Strobe the masked channels with one value; returns 1 time unit after the edge
    task automatic strobe(input logic [CH-1:0] m, input logic signed [DW-1:0] v);
        for (int k = 0; k < CH; k++)
            if (m[k]) data[k*DW +: DW] = v;
        valid = m;
        @(posedge clk); #1;
        valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = '0;
        #2;
        cmp++; if (intl !== 1'b0) begin errs++; $display("FAIL reset_intl got %b exp 0", intl); end
        cmp++; if (flag !== 10'h000) begin errs++; $display("FAIL reset_flag got %h exp 000", flag); end
        cmp++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", state); end
        cmp++; if (ddr !== 1'b0 || first_ch !== 4'd0 || first_val !== 32'd0) begin
            errs++; $display("FAIL reset_first got ddr=%b ch=%0d val=%0d exp 0/0/0", ddr, first_ch, first_val); end
        do_reset();
    endtask

    task automatic test_single_trip();
        do_reset();
        dly = 16'd3;
        strobe(10'h002, 32'sd1200);
        strobe(10'h002, 32'sd1200);
        cmp++; if (flag !== 10'h000) begin errs++; $display("FAIL single_early got %h exp 000", flag); end
        strobe(10'h002, 32'sd1200);
        cmp++; if (flag !== 10'h002 || intl !== 1'b1) begin errs++; $display("FAIL single_flag got %h/%b exp 002/1", flag, intl); end
        cmp++; if (first_ch !== 4'd1 || first_val !== 32'd1200) begin errs++; $display("FAIL single_first got %0d/%0d exp 1/1200", first_ch, first_val); end
        cmp++; if (ddr !== 1'b1 || state !== 2'd1) begin errs++; $display("FAIL single_ddr got %b/%0d exp 1/1", ddr, state); end
        @(posedge clk); #1;
        cmp++; if (ddr !== 1'b0) begin errs++; $display("FAIL single_ddr_len got %b exp 0", ddr); end
    endtask

    task automatic test_debounce();
        do_reset();
        dly = 16'd3;
        strobe(10'h001, 32'sd1200);
        strobe(10'h001, 32'sd1200);
        strobe(10'h001, 32'sd500);
        strobe(10'h001, 32'sd1200);
        strobe(10'h001, 32'sd1200);
        cmp++; if (flag !== 10'h000) begin errs++; $display("FAIL debounce_hold got %h exp 000", flag); end
        strobe(10'h001, 32'sd1200);
        cmp++; if (flag !== 10'h001 || first_ch !== 4'd0) begin errs++; $display("FAIL debounce_trip got %h/%0d exp 001/0", flag, first_ch); end
        do_reset();
        dly = 16'd5;
        strobe(10'h001, 32'sd1200);
        strobe(10'h001, 32'sd1200);
        strobe(10'h001, 32'sd1200);
        dly = 16'd2;
        strobe(10'h001, 32'sd1200);
        cmp++; if (flag !== 10'h001) begin errs++; $display("FAIL dly_change got %h exp 001", flag); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        dly = 16'd0;
        strobe(10'h100, 32'sd1000);
        strobe(10'h100, -32'sd1000);
        cmp++; if (flag !== 10'h000) begin errs++; $display("FAIL limit_edge got %h exp 000", flag); end
        strobe(10'h084, 32'sd5000);
        cmp++; if (flag !== 10'h084 || first_ch !== 4'd2 || first_val !== 32'd5000) begin
            errs++; $display("FAIL simul_first got %h/%0d/%0d exp 084/2/5000", flag, first_ch, first_val); end
        cmp++; if (ddr !== 1'b1) begin errs++; $display("FAIL simul_ddr got %b exp 1", ddr); end
        @(posedge clk); #1;
        strobe(10'h010, -32'sd3000);
        cmp++; if (flag !== 10'h094 || first_ch !== 4'd2 || first_val !== 32'd5000) begin
            errs++; $display("FAIL later_trip got %h/%0d/%0d exp 094/2/5000", flag, first_ch, first_val); end
        cmp++; if (ddr !== 1'b0 || state !== 2'd1) begin errs++; $display("FAIL later_ddr got %b/%0d exp 0/1", ddr, state); end
    endtask

    task automatic test_clear();
        do_reset();
        dly = 16'd1;
        lim_max[3*DW +: DW] = 32'sd4000;
        lim_min[3*DW +: DW] = -32'sd4000;
        strobe(10'h008, -32'sd5000);
        cmp++; if (flag !== 10'h008 || state !== 2'd1) begin errs++; $display("FAIL clr_trip got %h/%0d exp 008/1", flag, state); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        cmp++; if (state !== 2'd2 || flag !== 10'h008) begin errs++; $display("FAIL clr_hold got %0d/%h exp 2/008", state, flag); end
        strobe(10'h008, -32'sd5000);
        strobe(10'h008, 32'sd0);
        cmp++; if (state !== 2'd2 || flag !== 10'h008 || ddr !== 1'b0) begin
            errs++; $display("FAIL clr_persist got %0d/%h/%b exp 2/008/0", state, flag, ddr); end
        @(posedge clk); #1;
        cmp++; if (state !== 2'd0 || flag !== 10'h000 || intl !== 1'b0) begin
            errs++; $display("FAIL clr_rearm got %0d/%h/%b exp 0/000/0", state, flag, intl); end
        cmp++; if (first_ch !== 4'd0 || first_val !== 32'd0) begin errs++; $display("FAIL clr_first got %0d/%0d exp 0/0", first_ch, first_val); end
        strobe(10'h008, -32'sd5000);
        clr = 1'b1;
        @(posedge clk); #1;
        strobe(10'h008, 32'sd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp++; if (state !== 2'd2 || flag !== 10'h000) begin errs++; $display("FAIL clr_held got %0d/%h exp 2/000", state, flag); end
        clr = 1'b0;
        @(posedge clk); #1;
        cmp++; if (state !== 2'd0) begin errs++; $display("FAIL clr_release got %0d exp 0", state); end
    endtask

    task automatic test_collision_disable();
        do_reset();
        dly = 16'd1;
        clr = 1'b1;
        strobe(10'h020, 32'sd2000);
        clr = 1'b0;
        cmp++; if (flag !== 10'h020 || state !== 2'd1) begin errs++; $display("FAIL coll_armed got %h/%0d exp 020/1", flag, state); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        strobe(10'h020, 32'sd0);
        clr = 1'b1;
        strobe(10'h020, 32'sd2000);
        clr = 1'b0;
        cmp++; if (flag !== 10'h020 || state !== 2'd2) begin errs++; $display("FAIL coll_hold got %h/%0d exp 020/2", flag, state); end
        cmp++; if (ddr !== 1'b0 || first_ch !== 4'd5) begin errs++; $display("FAIL coll_first got %b/%0d exp 0/5", ddr, first_ch); end
        do_reset();
        dly = 16'd1;
        ch_en[6] = 1'b0;
        strobe(10'h040, 32'sd99999);
        strobe(10'h040, 32'sd99999);
        strobe(10'h040, 32'sd99999);
        cmp++; if (flag !== 10'h000 || intl !== 1'b0 || state !== 2'd0) begin
            errs++; $display("FAIL disable got %h/%b/%0d exp 000/0/0", flag, intl, state); end
        lim_max[9*DW +: DW] = -32'sd10;
        lim_min[9*DW +: DW] = 32'sd10;
        strobe(10'h200, 32'sd0);
        cmp++; if (flag !== 10'h200 || first_ch !== 4'd9) begin errs++; $display("FAIL misconfig got %h/%0d exp 200/9", flag, first_ch); end
    endtask

    task automatic test_async_reset();
        do_reset();
        dly = 16'd1;
        strobe(10'h002, 32'sd1200);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        cmp++; if (intl !== 1'b0 || flag !== 10'h000 || state !== 2'd0) begin
            errs++; $display("FAIL async_rst got %b/%h/%0d exp 0/000/0", intl, flag, state); end
        cmp++; if (first_ch !== 4'd0 || first_val !== 32'd0 || ddr !== 1'b0) begin
            errs++; $display("FAIL async_first got %0d/%0d/%b exp 0/0/0", first_ch, first_val, ddr); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        cmp++; if (state !== 2'd0 || flag !== 10'h000) begin errs++; $display("FAIL async_release got %0d/%h exp 0/000", state, flag); end
    endtask

    initial begin
        rst = 1'b1; valid = '0; clr = 1'b0; dly = '0; ch_en = '1;
        data = '0; lim_max = '0; lim_min = '0;
        test_reset();
        test_single_trip();
        test_debounce();
        test_simultaneous();
        test_clear();
        test_collision_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
